// File: rtl/detect_pkg.sv
// rtl/detect_pkg.sv - shared types and packing helpers for the detection collector
package detect_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_DRAIN,
    ST_TERM,
    ST_RESTART
  } collector_state_t;

  localparam logic [63:0] TERM_WORD = '1;

  function automatic int w_fill(input int w_out, input int w_x, input int w_y, input int w_s);
    return w_out - w_x - w_y - w_s;
  endfunction

  // Field widths are arguments so every collector parametrisation shares one helper.
  function automatic logic [63:0] pack_detect(input logic [63:0] scale, input logic [63:0] y,
                                              input logic [63:0] x, input int w_x, input int w_y);
    return (scale << (w_x + w_y)) | (y << w_x) | x;
  endfunction

endpackage

// File: rtl/detect_fifo.sv
// rtl/detect_fifo.sv - synchronous detection FIFO with full/empty flags
module detect_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_tdata_i,
  input  logic         in_tvalid_i,
  output logic [W-1:0] out_tdata_o,
  output logic         out_tvalid_o,
  input  logic         out_tready_i,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         push;
  logic         pop;

  assign empty_o      = (wr_q == rd_q);
  assign full_o       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // Full is judged before any pop this cycle, so a full FIFO never pushes.
  assign push         = in_tvalid_i && !full_o;
  assign pop          = out_tready_i && !empty_o;
  assign out_tvalid_o = !empty_o;
  assign out_tdata_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= in_tdata_i;
  end

endmodule

// File: rtl/detect_collector.sv
// rtl/detect_collector.sv - merges channel hits via round-robin into a FIFO and frames the output
module detect_collector
  import detect_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int W_X          = 9,
  parameter int W_Y          = 8,
  parameter int W_SCALE      = 4,
  parameter int W_OUT        = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int MAX_DET      = 255,
  parameter int DROP_ON_FULL = 1,
  parameter int W_CNT        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           cand_valid,
  output logic [N_CH-1:0]           cand_ready,
  input  logic [N_CH-1:0]           cand_hit,
  input  logic [N_CH-1:0]           cand_eot,
  input  logic [N_CH*W_X-1:0]       cand_x,
  input  logic [N_CH*W_Y-1:0]       cand_y,
  input  logic [N_CH*W_SCALE-1:0]   cand_scale,
  output logic                      detect_pos_valid,
  input  logic                      detect_pos_ready,
  output logic                      detect_pos_eot,
  output logic [W_OUT-1:0]          detect_pos,
  output logic                      detect_interrupt,
  output logic                      frame_restart,
  output logic [W_CNT-1:0]          drop_cnt
);

  localparam int W_ENT  = W_X + W_Y + W_SCALE;
  localparam int W_FILL = w_fill(W_OUT, W_X, W_Y, W_SCALE);
  localparam int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int W_DET  = $clog2(MAX_DET + 1);

  collector_state_t  state_q;
  logic [N_CH-1:0]   eot_mask_q, eot_mask_d;
  logic [W_DET-1:0]  det_cnt_q;
  logic [W_CNT-1:0]  drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  logic [N_CH-1:0]   active, hit_lane, ready_c, accept;
  logic              grant_vld;
  logic [PTR_W-1:0]  grant;
  logic              storable;
  logic              push;
  logic [W_ENT-1:0]  push_data;
  logic [W_ENT-1:0]  fifo_data;
  logic              fifo_out_valid;
  logic              fifo_full;
  logic              fifo_empty;
  logic [W_CNT:0]    drop_sum;
  int                idx;
  int                n_drop;

  assign storable = !fifo_full && (det_cnt_q < W_DET'(MAX_DET));

  // Grant goes to the first hitting, still-open channel at or after the pointer.
  always_comb begin
    active    = '0;
    hit_lane  = '0;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int c = 0; c < N_CH; c++) begin
      active[c]   = (state_q == ST_COLLECT) && !eot_mask_q[c];
      hit_lane[c] = active[c] && cand_hit[c];
    end
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!grant_vld && hit_lane[idx]) begin
        grant_vld = 1'b1;
        grant     = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    ready_c = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (!active[c])       ready_c[c] = 1'b0;
      else if (!cand_hit[c]) ready_c[c] = 1'b1;
      else if (storable)    ready_c[c] = grant_vld && (grant == PTR_W'(c));
      else                  ready_c[c] = (DROP_ON_FULL != 0);
    end
  end

  assign cand_ready = rst ? '0 : ready_c;
  assign accept     = cand_valid & cand_ready;
  assign push       = grant_vld && accept[grant] && storable;
  assign push_data  = W_ENT'(pack_detect(64'(cand_scale[int'(grant)*W_SCALE +: W_SCALE]),
                                         64'(cand_y[int'(grant)*W_Y +: W_Y]),
                                         64'(cand_x[int'(grant)*W_X +: W_X]), W_X, W_Y));
  assign ptr_d      = (grant == PTR_W'(N_CH - 1)) ? '0 : grant + 1'b1;
  assign eot_mask_d = eot_mask_q | (accept & cand_eot);

  // Any hit accepted while not storable is a drop; under backpressure none are accepted.
  always_comb begin
    n_drop = 0;
    if (!storable) begin
      for (int c = 0; c < N_CH; c++) begin
        if (accept[c] && cand_hit[c]) n_drop = n_drop + 1;
      end
    end
    drop_sum   = {1'b0, drop_cnt_q} + (W_CNT+1)'(n_drop);
    drop_cnt_d = drop_sum[W_CNT] ? '1 : drop_sum[W_CNT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_COLLECT;
      eot_mask_q <= '0;
      det_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ptr_q      <= '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          eot_mask_q <= eot_mask_d;
          drop_cnt_q <= drop_cnt_d;
          if (push) begin
            det_cnt_q <= det_cnt_q + 1'b1;
            ptr_q     <= ptr_d;
          end
          if (&eot_mask_d) state_q <= ST_DRAIN;
        end
        ST_DRAIN:   if (fifo_empty) state_q <= ST_TERM;
        ST_TERM:    if (detect_pos_ready) state_q <= ST_RESTART;
        ST_RESTART: begin
          eot_mask_q <= '0;
          det_cnt_q  <= '0;
          drop_cnt_q <= '0;
          ptr_q      <= '0;
          state_q    <= ST_COLLECT;
        end
        default:    state_q <= ST_COLLECT;
      endcase
    end
  end

  detect_fifo #(
    .W     (W_ENT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .in_tdata_i   (push_data),
    .in_tvalid_i  (push),
    .out_tdata_o  (fifo_data),
    .out_tvalid_o (fifo_out_valid),
    .out_tready_i (detect_pos_ready),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  assign detect_pos_eot   = (state_q == ST_TERM);
  assign detect_interrupt = detect_pos_eot;
  assign detect_pos_valid = detect_pos_eot || fifo_out_valid;
  assign detect_pos       = detect_pos_eot ? W_OUT'(TERM_WORD) :
                            fifo_out_valid ? {{W_FILL{1'b0}}, fifo_data} : '0;
  assign frame_restart    = (state_q == ST_RESTART);
  assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_detect_collector.sv
// tb/tb_detect_collector.sv - directed self-checking bench for detect_collector
module tb_detect_collector;

  typedef struct packed {
    logic       hit;
    logic       eot;
    logic [8:0] x;
    logic [7:0] y;
    logic [3:0] s;
  } cand_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cv [3];
  logic [1:0]  cr [3];
  logic [1:0]  chh [3];
  logic [1:0]  ce [3];
  logic [17:0] cx [3];
  logic [15:0] cy [3];
  logic [7:0]  cs [3];
  logic        pv [3];
  logic        prdy [3];
  logic        peot [3];
  logic        pint [3];
  logic        frs [3];
  logic [31:0] pos [3];
  logic [15:0] dcnt [3];

  int n_cmp = 0;
  int n_bad = 0;

  cand_t       q0[$];
  cand_t       q1[$];
  logic [31:0] words[$];
  logic [31:0] term_word;
  logic [15:0] drop_at_term;
  int          term_n, term_cyc, restart_n, restart_cyc, int_bad, max_drop, dip0, dip1;

  always #5 clk = ~clk;

  // A: depth 4 drop mode, B: depth 4 backpressure, C: detection cap of 2
  detect_collector #(.FIFO_DEPTH(4), .DROP_ON_FULL(1)) dut_a (
    .clk(clk), .rst(rst), .cand_valid(cv[0]), .cand_ready(cr[0]), .cand_hit(chh[0]),
    .cand_eot(ce[0]), .cand_x(cx[0]), .cand_y(cy[0]), .cand_scale(cs[0]),
    .detect_pos_valid(pv[0]), .detect_pos_ready(prdy[0]), .detect_pos_eot(peot[0]),
    .detect_pos(pos[0]), .detect_interrupt(pint[0]), .frame_restart(frs[0]), .drop_cnt(dcnt[0]));

  detect_collector #(.FIFO_DEPTH(4), .DROP_ON_FULL(0)) dut_b (
    .clk(clk), .rst(rst), .cand_valid(cv[1]), .cand_ready(cr[1]), .cand_hit(chh[1]),
    .cand_eot(ce[1]), .cand_x(cx[1]), .cand_y(cy[1]), .cand_scale(cs[1]),
    .detect_pos_valid(pv[1]), .detect_pos_ready(prdy[1]), .detect_pos_eot(peot[1]),
    .detect_pos(pos[1]), .detect_interrupt(pint[1]), .frame_restart(frs[1]), .drop_cnt(dcnt[1]));

  detect_collector #(.MAX_DET(2)) dut_c (
    .clk(clk), .rst(rst), .cand_valid(cv[2]), .cand_ready(cr[2]), .cand_hit(chh[2]),
    .cand_eot(ce[2]), .cand_x(cx[2]), .cand_y(cy[2]), .cand_scale(cs[2]),
    .detect_pos_valid(pv[2]), .detect_pos_ready(prdy[2]), .detect_pos_eot(peot[2]),
    .detect_pos(pos[2]), .detect_interrupt(pint[2]), .frame_restart(frs[2]), .drop_cnt(dcnt[2]));

  function automatic cand_t mk(input bit hit, input bit eot, input int x, input int y, input int s);
    cand_t c;
    c.hit = hit; c.eot = eot; c.x = 9'(x); c.y = 8'(y); c.s = 4'(s);
    return c;
  endfunction

  // Presents the channel queues to instance d and records every output beat.
  task automatic run_frame(input int d, input int rdy_start, input int max_cyc);
    cand_t h0, h1;
    int    cyc;
    bit    done;
    words.delete();
    term_n = 0; term_cyc = 0; restart_n = 0; restart_cyc = -1; int_bad = 0;
    max_drop = 0; dip0 = 0; dip1 = 0; drop_at_term = '0; term_word = '0;
    cyc = 0; done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      h0 = (q0.size() > 0) ? q0[0] : '0;
      h1 = (q1.size() > 0) ? q1[0] : '0;
      cv[d]   = {q1.size() > 0, q0.size() > 0};
      chh[d]  = {h1.hit, h0.hit};
      ce[d]   = {h1.eot, h0.eot};
      cx[d]   = {h1.x, h0.x};
      cy[d]   = {h1.y, h0.y};
      cs[d]   = {h1.s, h0.s};
      prdy[d] = (cyc >= rdy_start);
      @(negedge clk);
      if (q0.size() > 0) begin
        if (cr[d][0]) void'(q0.pop_front()); else dip0++;
      end
      if (q1.size() > 0) begin
        if (cr[d][1]) void'(q1.pop_front()); else dip1++;
      end
      if (pint[d] !== peot[d]) int_bad++;
      if (frs[d] === 1'b1) begin restart_n++; restart_cyc = cyc; end
      if (int'(dcnt[d]) > max_drop) max_drop = int'(dcnt[d]);
      if (pv[d] && prdy[d]) begin
        if (peot[d]) begin
          term_n++; term_word = pos[d]; term_cyc = cyc; drop_at_term = dcnt[d];
        end else begin
          words.push_back(pos[d]);
        end
      end
      cyc++;
      if ((term_n > 0 && cyc > term_cyc + 3) || cyc >= max_cyc) done = 1'b1;
    end
    cv[d] = '0; chh[d] = '0; ce[d] = '0; prdy[d] = 1'b0;
    q0.delete(); q1.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (cr[d] !== 2'b00) begin $display("FAIL reset_ready[%0d]: got %b want 00", d, cr[d]); n_bad++; end
      n_cmp++;
      if (pv[d] !== 1'b0 || peot[d] !== 1'b0 || frs[d] !== 1'b0) begin
        $display("FAIL reset_outs[%0d]: valid=%b eot=%b restart=%b want 000", d, pv[d], peot[d], frs[d]); n_bad++;
      end
      n_cmp++;
      if (dcnt[d] !== 16'd0) begin $display("FAIL reset_drop[%0d]: got %0d want 0", d, dcnt[d]); n_bad++; end
      n_cmp++;
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (cr[d] !== 2'b11) begin $display("FAIL post_reset_ready[%0d]: got %b want 11", d, cr[d]); n_bad++; end
      n_cmp++;
    end
  endtask

  task automatic test_merge();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h0002_0605; exp_w[1] = 32'h0000_0407;
    exp_w[2] = 32'h0004_0201; exp_w[3] = 32'h0006_0809;
    q0.push_back(mk(1, 0, 5, 3, 1)); q0.push_back(mk(1, 1, 1, 1, 2));
    q1.push_back(mk(1, 0, 7, 2, 0)); q1.push_back(mk(1, 1, 9, 4, 3));
    run_frame(0, 0, 100);
    if (words.size() != 4) begin $display("FAIL merge_count: got %0d want 4", words.size()); n_bad++; end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      if (i < words.size()) begin
        if (words[i] !== exp_w[i]) begin $display("FAIL merge_word[%0d]: got %h want %h", i, words[i], exp_w[i]); n_bad++; end
        n_cmp++;
      end
    end
    if (term_n != 1 || term_word !== 32'hFFFF_FFFF) begin
      $display("FAIL merge_term: count=%0d word=%h want 1 ffffffff", term_n, term_word); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_nonhit();
    for (int i = 0; i < 11; i++) begin
      q0.push_back(mk(0, i == 10, i, i, 0));
      q1.push_back(mk(0, i == 10, i + 20, i, 1));
    end
    run_frame(0, 0, 100);
    if (words.size() != 0) begin $display("FAIL nonhit_words: got %0d want 0", words.size()); n_bad++; end
    n_cmp++;
    if (dip0 != 0 || dip1 != 0) begin $display("FAIL nonhit_ready: stalls %0d/%0d want 0/0", dip0, dip1); n_bad++; end
    n_cmp++;
    if (term_n != 1 || term_word !== 32'hFFFF_FFFF) begin
      $display("FAIL nonhit_term: count=%0d word=%h want 1 ffffffff", term_n, term_word); n_bad++;
    end
    n_cmp++;
    if (int_bad != 0) begin $display("FAIL nonhit_irq: %0d cycles interrupt != eot, want 0", int_bad); n_bad++; end
    n_cmp++;
    if (restart_n != 1 || restart_cyc != term_cyc + 1) begin
      $display("FAIL nonhit_restart: pulses=%0d at %0d want 1 at %0d", restart_n, restart_cyc, term_cyc + 1); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_drop_full();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h001; exp_w[1] = 32'h202; exp_w[2] = 32'h403; exp_w[3] = 32'h604;
    for (int i = 0; i < 7; i++) q0.push_back(mk(1, i == 6, i + 1, i, 0));
    q1.push_back(mk(0, 1, 0, 0, 0));
    run_frame(0, 20, 100);
    if (dip0 != 0) begin $display("FAIL drop_ready: ch0 stalled %0d cycles want 0", dip0); n_bad++; end
    n_cmp++;
    if (drop_at_term !== 16'd3) begin $display("FAIL drop_cnt: got %0d want 3", drop_at_term); n_bad++; end
    n_cmp++;
    if (words.size() != 4) begin $display("FAIL drop_count: got %0d want 4", words.size()); n_bad++; end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      if (i < words.size()) begin
        if (words[i] !== exp_w[i]) begin $display("FAIL drop_word[%0d]: got %h want %h", i, words[i], exp_w[i]); n_bad++; end
        n_cmp++;
      end
    end
    if (term_n != 1) begin $display("FAIL drop_term: got %0d want 1", term_n); n_bad++; end
    n_cmp++;
    if (dcnt[0] !== 16'd0) begin $display("FAIL drop_clear: got %0d want 0", dcnt[0]); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [7];
    exp_w[0] = 32'h001; exp_w[1] = 32'h202; exp_w[2] = 32'h403; exp_w[3] = 32'h604;
    exp_w[4] = 32'h805; exp_w[5] = 32'hA06; exp_w[6] = 32'hC07;
    for (int i = 0; i < 7; i++) q0.push_back(mk(1, i == 6, i + 1, i, 0));
    q1.push_back(mk(0, 1, 0, 0, 0));
    run_frame(1, 20, 100);
    if (dip0 != 17) begin $display("FAIL bp_stall: ch0 stalled %0d cycles want 17", dip0); n_bad++; end
    n_cmp++;
    if (max_drop != 0) begin $display("FAIL bp_drop: got %0d want 0", max_drop); n_bad++; end
    n_cmp++;
    if (words.size() != 7) begin $display("FAIL bp_count: got %0d want 7", words.size()); n_bad++; end
    n_cmp++;
    for (int i = 0; i < 7; i++) begin
      if (i < words.size()) begin
        if (words[i] !== exp_w[i]) begin $display("FAIL bp_word[%0d]: got %h want %h", i, words[i], exp_w[i]); n_bad++; end
        n_cmp++;
      end
    end
    if (term_n != 1) begin $display("FAIL bp_term: got %0d want 1", term_n); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_cap();
    q0.push_back(mk(1, 0, 10, 1, 5)); q0.push_back(mk(1, 0, 11, 1, 5)); q0.push_back(mk(1, 1, 12, 1, 5));
    q1.push_back(mk(0, 1, 0, 0, 0));
    run_frame(2, 0, 100);
    if (words.size() != 2) begin $display("FAIL cap_count: got %0d want 2", words.size()); n_bad++; end
    n_cmp++;
    if (words.size() == 2) begin
      if (words[0] !== 32'h000A_020A || words[1] !== 32'h000A_020B) begin
        $display("FAIL cap_words: got %h %h want 000a020a 000a020b", words[0], words[1]); n_bad++;
      end
      n_cmp++;
    end
    if (drop_at_term !== 16'd1) begin $display("FAIL cap_drop: got %0d want 1", drop_at_term); n_bad++; end
    n_cmp++;
    if (dip0 != 0) begin $display("FAIL cap_ready: ch0 stalled %0d cycles want 0", dip0); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_mid_reset();
    int pulses;
    q0.push_back(mk(1, 0, 1, 1, 1)); q0.push_back(mk(1, 0, 2, 2, 2)); q0.push_back(mk(1, 1, 3, 3, 3));
    run_frame(1, 1000, 6);
    #1;
    if (cr[1] !== 2'b10 || pv[1] !== 1'b1) begin
      $display("FAIL midrst_pre: ready=%b valid=%b want 10 1", cr[1], pv[1]); n_bad++;
    end
    n_cmp++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    if (pv[1] !== 1'b0 || cr[1] !== 2'b11 || dcnt[1] !== 16'd0 || frs[1] !== 1'b0) begin
      $display("FAIL midrst_post: valid=%b ready=%b drop=%0d restart=%b want 0 11 0 0", pv[1], cr[1], dcnt[1], frs[1]); n_bad++;
    end
    n_cmp++;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (frs[1] !== 1'b0 || peot[1] !== 1'b0) pulses++;
    end
    if (pulses != 0) begin $display("FAIL midrst_quiet: %0d cycles with restart/eot want 0", pulses); n_bad++; end
    n_cmp++;
    q0.push_back(mk(0, 1, 0, 0, 0)); q1.push_back(mk(0, 1, 0, 0, 0));
    run_frame(1, 0, 60);
    if (words.size() != 0 || term_n != 1 || restart_n != 1) begin
      $display("FAIL midrst_frame: words=%0d terms=%0d restarts=%0d want 0 1 1", words.size(), term_n, restart_n); n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      cv[d] = '0; chh[d] = '0; ce[d] = '0; cx[d] = '0; cy[d] = '0; cs[d] = '0; prdy[d] = 1'b0;
    end
    test_reset();
    test_merge();
    test_nonhit();
    test_drop_full();
    test_backpressure();
    test_cap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
